nibble_serial_adder: RTL and testbench
======================================

NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

Interface
REQ-001 SHALL have parameter NIBBLES, default 4: number of 4-bit slices per operand; W = 4*NIBBLES; legal range 2..16.
REQ-002 SHALL have port clk, input, 1: sole clock, rising-edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1: operands present.
REQ-005 SHALL have port in_ready, output, 1: block can accept operands.
REQ-006 SHALL have port a, input, W: operand A.
REQ-007 SHALL have port b, input, W: operand B.
REQ-008 SHALL have port cin, input, 1: carry-in to nibble 0.
REQ-009 SHALL have port out_valid, output, 1: result present.
REQ-010 SHALL have port out_ready, input, 1: consumer takes the result.
REQ-011 SHALL have port sum, output, W: registered result, a+b+cin mod 2^W.
REQ-012 SHALL have port cout, output, 1: carry out of the top nibble.
REQ-013 SHALL have port ovf, output, 1: signed overflow; present only per REQ-027.

Function
REQ-014 SHALL implement FSM states IDLE, ADD, DONE.
REQ-015 IDLE: in_ready=1, out_valid=0; on in_valid=1 at an edge, SHALL capture a, b, cin, clear the sum register, set idx=0, and go to ADD.
REQ-016 ADD: each edge SHALL add nibble idx of the captured a and b plus the carry register via a 4-bit carry-lookahead slice, write the 4-bit result to sum[4*idx+3:4*idx], load the slice carry-out into the carry register, and increment idx.
REQ-017 ADD: at the edge processing idx=NIBBLES-1, SHALL load cout from the slice carry-out and go to DONE.
REQ-018 DONE: out_valid=1 and in_ready=0; sum, cout and ovf SHALL stay stable until out_ready=1 at an edge; then go to IDLE.
REQ-019 Latency SHALL be exactly NIBBLES cycles from the acceptance edge to the first cycle with out_valid=1; throughput is one operation per NIBBLES+2 cycles at best.
REQ-020 in_ready SHALL be 0 in ADD and DONE; in_valid in those states SHALL be ignored, with no queuing.
REQ-021 Changes on a, b or cin after acceptance SHALL NOT affect the result.
REQ-022 out_ready in IDLE or ADD SHALL be ignored.
REQ-023 The carry chain SHALL wrap modulo 2^W; the carry out of the top nibble goes only to cout.
REQ-024 in_ready SHALL be a registered-state decode with no combinational path from in_valid or out_ready.

Reset
REQ-025 rst=1 SHALL immediately force state=IDLE, idx=0, carry=0, sum=0, cout=0, ovf=0, out_valid=0, in_ready=1, in any state including mid-ADD.
REQ-026 An operation interrupted by reset SHALL be discarded; the first edge after rst falls behaves as IDLE.

Configuration
REQ-027 Macro NIBBLE_SERIAL_ADDER_OVF_EN: when defined, port ovf exists and, at the DONE transition, is loaded with the XOR of the carry into and out of bit W-1; when undefined, the port and its logic are absent.

Structure
REQ-028 Package nsa_pkg SHALL hold the state enum (IDLE/ADD/DONE) and the constant NIBBLE_W=4.
REQ-029 The 4-bit combinational lookahead slice SHALL be sub-module cla4_slice (a, b, cin -> s, cout), instantiated once and time-shared; all registers stay in nibble_serial_adder.

Verification
REQ-030 a=0xFFFF, b=0x0001, cin=0 -> after 4 cycles out_valid=1, sum=0x0000, cout=1.
REQ-031 a=0x1234, b=0x4321, cin=1 -> sum=0x5556, cout=0; in_ready low for the whole operation.
REQ-032 out_ready held 0 for 3 cycles in DONE -> sum and cout unchanged for all 3 cycles; IDLE on the first edge with out_ready=1.
REQ-033 rst pulsed at idx=2 -> all outputs 0 and in_ready=1 at once; the next operation 0x0F0F+0x00F1 gives 0x1000.
REQ-034 in_valid held high during ADD with changing a and b -> only the first operands are used; exactly one result is produced.
REQ-035 With OVF_EN: 0x7FFF+0x0001 -> ovf=1, sum=0x8000; 0xFFFF+0x0001 -> ovf=0.

Source files
------------

// File: rtl/nsa_pkg.sv
// Shared types and constants for the nibble-serial adder.
package nsa_pkg;

   localparam int unsigned NIBBLE_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/cla4_slice.sv
// 4-bit combinational carry-lookahead slice, time-shared by the serial adder.
module cla4_slice
   import nsa_pkg::*;
(
   input  logic [NIBBLE_W-1:0] a,
   input  logic [NIBBLE_W-1:0] b,
   input  logic                cin,
   output logic [NIBBLE_W-1:0] s,
   output logic                cout
);

   logic [NIBBLE_W-1:0] w_g;
   logic [NIBBLE_W-1:0] w_p;
   logic [NIBBLE_W-1:0] w_c;

   assign w_g = a & b;
   assign w_p = a ^ b;

   // Flattened lookahead carries; no ripple between bit positions.
   assign w_c[0] = cin;
   assign w_c[1] = w_g[0] | (w_p[0] & cin);
   assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & cin);
   assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                 | (w_p[2] & w_p[1] & w_p[0] & cin);
   assign cout   = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                 | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                 | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & cin);

   assign s = w_p ^ w_c;

endmodule

// File: rtl/nibble_serial_adder.sv
// Serial adder: one 4-bit lookahead slice per cycle over NIBBLES nibbles.
// Optional signed-overflow output enabled by NIBBLE_SERIAL_ADDER_OVF_EN.
module nibble_serial_adder
   import nsa_pkg::*;
#(
   parameter int unsigned NIBBLES = 4
)(
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [NIBBLE_W*NIBBLES-1:0]  a,
   input  logic [NIBBLE_W*NIBBLES-1:0]  b,
   input  logic                         cin,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [NIBBLE_W*NIBBLES-1:0]  sum,
   output logic                         cout
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
   ,output logic                        ovf
`endif
);

   localparam int unsigned W     = NIBBLE_W * NIBBLES;
   localparam int unsigned IDX_W = $clog2(NIBBLES);

   state_t              r_state;
   state_t              w_state_next;
   logic [W-1:0]        r_a;
   logic [W-1:0]        r_b;
   logic [W-1:0]        r_sum;
   logic [IDX_W-1:0]    r_idx;
   logic                r_carry;
   logic                r_cout;
   logic                r_in_ready;
   logic                r_out_valid;
   logic [NIBBLE_W-1:0] w_a_nib;
   logic [NIBBLE_W-1:0] w_b_nib;
   logic [NIBBLE_W-1:0] w_s;
   logic                w_co;
   logic                w_last;

   assign w_a_nib = r_a[{r_idx, 2'b00} +: NIBBLE_W];
   assign w_b_nib = r_b[{r_idx, 2'b00} +: NIBBLE_W];
   assign w_last  = (r_idx == IDX_W'(NIBBLES - 1));

   cla4_slice u_slice (
      .a    (w_a_nib),
      .b    (w_b_nib),
      .cin  (r_carry),
      .s    (w_s),
      .cout (w_co)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (in_valid)  w_state_next = ADD;
         ADD:     if (w_last)    w_state_next = DONE;
         DONE:    if (out_ready) w_state_next = IDLE;
         default:                w_state_next = IDLE;
      endcase
   end

   // Handshake flags are flopped copies of the next-state decode.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
      end else begin
         r_in_ready  <= (w_state_next == IDLE);
         r_out_valid <= (w_state_next == DONE);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a     <= '0;
         r_b     <= '0;
         r_sum   <= '0;
         r_idx   <= '0;
         r_carry <= 1'b0;
         r_cout  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: if (in_valid) begin
               r_a     <= a;
               r_b     <= b;
               r_carry <= cin;
               r_sum   <= '0;
               r_idx   <= '0;
            end
            ADD: begin
               r_sum[{r_idx, 2'b00} +: NIBBLE_W] <= w_s;
               r_carry <= w_co;
               r_idx   <= r_idx + IDX_W'(1);
               if (w_last) r_cout <= w_co;
            end
            default: ;
         endcase
      end
   end

`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
   logic r_ovf;
   logic w_ovf;

   // Carry into the sign bit recovered as a^b^s of bit 3 in the top slice.
   assign w_ovf = w_a_nib[NIBBLE_W-1] ^ w_b_nib[NIBBLE_W-1] ^ w_s[NIBBLE_W-1] ^ w_co;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                            r_ovf <= 1'b0;
      else if ((r_state == ADD) && w_last) r_ovf <= w_ovf;
   end

   assign ovf = r_ovf;
`endif

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign sum       = r_sum;
   assign cout      = r_cout;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder (default NIBBLES=4).
module tb_nibble_serial_adder;

   localparam int unsigned NIBBLES = 4;
   localparam int unsigned W       = 4 * NIBBLES;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum;
   logic         cout;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
   logic         ovf;
`endif

   int checks = 0;
   int errors = 0;
   int d_results = 0;

   always #5 clk = ~clk;

   nibble_serial_adder #(.NIBBLES(NIBBLES)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout)
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
      ,.ovf      (ovf)
`endif
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Reference: plain integer add, plus the transaction timing rules.
   function automatic logic [W+1:0] f_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
      logic [W:0] t;
      logic       v;
      t = {1'b0, x} + {1'b0, y} + (W+1)'(c);
      v = (x[W-1] == y[W-1]) && (t[W-1] != x[W-1]);
      return {v, t};
   endfunction

   typedef enum {M_IDLE, M_BUSY, M_DONE} mphase_t;
   mphase_t      m_phase = M_IDLE;
   int           m_cnt   = 0;
   logic [W-1:0] m_sum   = '0;
   logic         m_cout  = 1'b0;
   logic         m_ovf   = 1'b0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_phase <= M_IDLE;
         m_cnt   <= 0;
      end else begin
         case (m_phase)
            M_IDLE: if (in_valid) begin
               {m_ovf, m_cout, m_sum} <= f_add(a, b, cin);
               m_cnt   <= 0;
               m_phase <= M_BUSY;
            end
            M_BUSY: begin
               m_cnt <= m_cnt + 1;
               if (m_cnt == NIBBLES - 1) m_phase <= M_DONE;
            end
            M_DONE: if (out_ready) m_phase <= M_IDLE;
            default: m_phase <= M_IDLE;
         endcase
      end
   end

   always @(posedge clk)
      if (!rst && out_valid && out_ready) d_results <= d_results + 1;

   always @(negedge clk) begin
      chk("model_in_ready", in_ready, m_phase == M_IDLE);
      chk("model_out_valid", out_valid, m_phase == M_DONE);
      if (m_phase == M_DONE) begin
         chk("model_sum", sum, m_sum);
         chk("model_cout", cout, m_cout);
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
         chk("model_ovf", ovf, m_ovf);
`endif
      end
   end

   // Called and returns on a falling edge with the DUT idle.
   task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                         input logic [W-1:0] es, input logic ec, input logic eo, input int hold);
      int n;
      a = ta; b = tb_v; cin = tc; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0; a = ~ta; b = ~tb_v; cin = ~tc;
      n = 0;
      while (!out_valid && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("latency", n, NIBBLES);
      chk("sum", sum, es);
      chk("cout", cout, ec);
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
      chk("ovf", ovf, eo);
`else
      if (eo === 1'bx) $display("unexpected x in ovf vector");
`endif
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("hold_valid", out_valid, 1'b1);
         chk("hold_sum", sum, es);
         chk("hold_cout", cout, ec);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("release_in_ready", in_ready, 1'b1);
      chk("release_out_valid", out_valid, 1'b0);
   endtask

   initial begin
      int n;
      int d0;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; cin = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_sum", sum, 16'h0000);
      chk("rst_cout", cout, 1'b0);
      rst = 1'b0;
      @(negedge clk);

      run_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 0);
      run_op(16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0, 0);
      run_op(16'hA5A5, 16'h5A5A, 1'b0, 16'hFFFF, 1'b0, 1'b0, 3);

      // Reset while idx=2 discards the operation at once.
      a = 16'h1234; b = 16'h1111; cin = 1'b0; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      #1 rst = 1'b1;
      #1;
      chk("midrst_out_valid", out_valid, 1'b0);
      chk("midrst_in_ready", in_ready, 1'b1);
      chk("midrst_sum", sum, 16'h0000);
      chk("midrst_cout", cout, 1'b0);
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
      chk("midrst_ovf", ovf, 1'b0);
`endif
      @(negedge clk);
      rst = 1'b0;
      run_op(16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0, 0);

      // in_valid held with changing operands during ADD.
      d0 = d_results;
      a = 16'h1111; b = 16'h2222; cin = 1'b0; in_valid = 1'b1;
      @(negedge clk);
      n = 0;
      while (!out_valid && n < 40) begin
         a = a + 16'h0101; b = b + 16'h0010;
         @(negedge clk);
         n++;
      end
      in_valid = 1'b0;
      chk("hold_in_valid_sum", sum, 16'h3333);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("single_result_idle", out_valid, 1'b0);
      end
      chk("single_result_count", d_results - d0, 1);

      run_op(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 0);
      run_op(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 0);
      run_op(16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0, 1);
      run_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 0);

      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
